regfile_tagged: RTL and testbench
=================================

# regfile_tagged

Architectural register file with per-register rename status. It sits directly downstream of the writeback/reorder-buffer commit stage and consumes its two in-order commit ports. It also accepts up to four rename claims per cycle from dispatch. It serves eight operand reads (four instructions × two sources), each returning value, busy flag and producer tag, so dispatch can forward a tag to the ROB lookup ports.

## Interface
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero.
- TAG_W, 32, ROB tag width; must match the commit-stage tag.
- CLK  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-low; sampled on the CLK rising edge.
- RegFileWE1, RegFileWE2  in  1  commit write enables; port 1 is older than port 2 when both are set.
- RegFileWA1, RegFileWA2  in  5  commit register addresses.
- RegFileWD1, RegFileWD2  in  32  commit data.
- RegFileWD1Tag, RegFileWD2Tag  in  TAG_W  ROB tag of each committing instruction.
- RenWE0..RenWE3  in  1  rename claim valid; index 0 is oldest in program order.
- RenWA0..RenWA3  in  5  destination register being claimed.
- RenTag0..RenTag3  in  TAG_W  ROB tag assigned to the claiming instruction.
- Flush  in  1  mispredict recovery; clears all busy flags.
- RA0A, RA0B … RA3A, RA3B  in  5  operand read addresses.
- RD0A … RD3B  out  32  operand value.
- RBusy0A … RBusy3B  out  1  1 = value still pending; use RTag.
- RTag0A … RTag3B  out  TAG_W  producer tag; 0 when not busy.

## Operation
- Per-register state: value[31:0], busy, tag[TAG_W-1:0].
- Commit, port p enabled with WA≠0:
  - value ← WD.
  - busy ← 0 only if the stored tag equals WDTag and no rename claim in the same cycle targets that register.
  - A stale commit (tag mismatch) writes the value but leaves busy and tag untouched.
- Both commit ports on the same register: port 2 is applied last, so its value wins. Busy clears if either port's tag matches.
- Rename claim k with WA≠0: busy ← 1, tag ← RenTag_k. Claims override any same-cycle commit busy clear.
- Several claims to one register in a cycle: the highest index wins.
- Flush: every busy ← 0 and every tag ← 0. Commits in the same cycle still write values. Rename claims in a Flush cycle are ignored.
- Register 0: all writes are ignored. It always reads value 0, busy 0, tag 0.
- Reads are combinational from the stored state, with commit bypass:
  - If a same-cycle commit targets RA, RD returns the committed data (port 2 priority).
  - If that commit's tag matches the stored tag, RBusy reads 0.
  - Same-cycle rename claims are not visible to reads. Intra-group dependency is resolved by dispatch.
- Reset (Reset=0 at an edge): all values, busy flags and tags ← 0. Reset has priority over Flush, commit and rename.

## Timing
- State updates on the CLK rising edge. Claims and commits are visible to registered reads on the next cycle.
- Read latency is zero (combinational). Commit data and busy clear are bypassed in the same cycle.
- Output values during and after reset: every RD, RBusy and RTag is 0.
- There is no handshake and no stall. Every enabled claim and commit is accepted each cycle.
- Reset asserted mid-operation discards all pending busy state; subsequent commits carrying old tags are stale and write value only.

## Structure
- Shared package regfile_pkg: NUM_REGS, TAG_W, REG_ADDR_W=5, and a regstat_t struct {value, busy, tag}.
- One natural sub-module, regfile_rdport: the combinational read mux with commit bypass. Instantiate it eight times.
- Priority resolution for claims and commits lives in the top module as a per-register next-state loop.

## Test plan
- Reset: drive Reset=0 for 2 cycles → all eight reads return RD=0, RBusy=0, RTag=0.
- Claim R5 tag 7, next cycle commit R5 data 0xDEADBEEF tag 7 → during the commit cycle RD=0xDEADBEEF, RBusy=0; the following cycle is the same from storage.
- Claim R5 tag 7, then claim R5 tag 9, then commit R5 tag 7 data 0x11 → RD=0x11, RBusy=1, RTag=9.
- Same cycle: commit R3 tag 4 data 0x22 and claim R3 tag 12 → next cycle RD=0x22, RBusy=1, RTag=12. Separately, RenWE0 and RenWE2 both claim R8 with tags 20 and 22 → RTag=22.
- Commit both ports to R6: port 1 data 0x1, port 2 data 0x2 → RD=0x2. Any write or claim to R0 → R0 reads 0, not busy.
- Claim R1..R4 busy, then pulse Flush with a simultaneous claim of R10 → all RBusy=0, R10 not busy, previously committed values unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the tagged architectural register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int TAG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_RD     = 8;
    localparam int NUM_REN    = 4;

    // Architectural state held per register.
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              busy;
        logic [TAG_W-1:0]  tag;
    } regstat_t;

    // One in-order commit port from writeback/ROB.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
        logic [TAG_W-1:0]      tag;
    } commit_t;

    // One rename claim from dispatch.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] wa;
        logic [TAG_W-1:0]      tag;
    } claim_t;

    // A commit only ever affects a nonzero register it addresses.
    function automatic logic commit_hits(input commit_t c, input logic [REG_ADDR_W-1:0] a);
        return c.we && (c.wa == a) && (a != '0);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One operand read port: stored value/busy/tag with same-cycle commit bypass.
// Latency: zero, purely combinational.
// Backpressure: none; always produces a result.
// Ports: i_rst_n forces zero output while reset is held, i_ra read address,
//        i_regs full register state, i_cmt1/i_cmt2 commit ports (port 2 younger),
//        o_rd value, o_rbusy pending flag, o_rtag producer tag (0 when not busy).
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_ra,
    input  regstat_t              i_regs [NUM_REGS],
    input  commit_t               i_cmt1,
    input  commit_t               i_cmt2,
    output logic [DATA_W-1:0]     o_rd,
    output logic                  o_rbusy,
    output logic [TAG_W-1:0]      o_rtag
);

    regstat_t w_stat;
    logic     w_hit1;
    logic     w_hit2;

    assign w_stat = i_regs[i_ra];
    assign w_hit1 = commit_hits(i_cmt1, i_ra);
    assign w_hit2 = commit_hits(i_cmt2, i_ra);

    always_comb begin
        o_rd    = '0;
        o_rbusy = 1'b0;
        o_rtag  = '0;
        if (i_rst_n && (i_ra != '0)) begin
            o_rd    = w_stat.value;
            o_rbusy = w_stat.busy;
            // Port 2 is younger, so its data is the one the reader must see.
            if (w_hit1) o_rd = i_cmt1.wd;
            if (w_hit2) o_rd = i_cmt2.wd;
            // A matching-tag commit retires the producer this very cycle.
            if ((w_hit1 && (i_cmt1.tag == w_stat.tag)) ||
                (w_hit2 && (i_cmt2.tag == w_stat.tag)))
                o_rbusy = 1'b0;
            o_rtag = o_rbusy ? w_stat.tag : '0;
        end
    end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy flag and producer tag.
// Latency: reads combinational (commit bypassed); claims/commits stored on next edge.
// Backpressure: none; every enabled claim and commit is accepted each cycle.
// Ports: i_clk, i_reset (sync active-low), two commit ports, four rename claims,
//        i_flush, eight read addresses; outputs value/busy/tag per read.
module regfile_tagged
    import regfile_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_regfile_we1,
    input  logic                  i_regfile_we2,
    input  logic [REG_ADDR_W-1:0] i_regfile_wa1,
    input  logic [REG_ADDR_W-1:0] i_regfile_wa2,
    input  logic [DATA_W-1:0]     i_regfile_wd1,
    input  logic [DATA_W-1:0]     i_regfile_wd2,
    input  logic [TAG_W-1:0]      i_regfile_wd1_tag,
    input  logic [TAG_W-1:0]      i_regfile_wd2_tag,
    input  logic                  i_ren_we0,
    input  logic                  i_ren_we1,
    input  logic                  i_ren_we2,
    input  logic                  i_ren_we3,
    input  logic [REG_ADDR_W-1:0] i_ren_wa0,
    input  logic [REG_ADDR_W-1:0] i_ren_wa1,
    input  logic [REG_ADDR_W-1:0] i_ren_wa2,
    input  logic [REG_ADDR_W-1:0] i_ren_wa3,
    input  logic [TAG_W-1:0]      i_ren_tag0,
    input  logic [TAG_W-1:0]      i_ren_tag1,
    input  logic [TAG_W-1:0]      i_ren_tag2,
    input  logic [TAG_W-1:0]      i_ren_tag3,
    input  logic                  i_flush,
    input  logic [REG_ADDR_W-1:0] i_ra0a,
    input  logic [REG_ADDR_W-1:0] i_ra0b,
    input  logic [REG_ADDR_W-1:0] i_ra1a,
    input  logic [REG_ADDR_W-1:0] i_ra1b,
    input  logic [REG_ADDR_W-1:0] i_ra2a,
    input  logic [REG_ADDR_W-1:0] i_ra2b,
    input  logic [REG_ADDR_W-1:0] i_ra3a,
    input  logic [REG_ADDR_W-1:0] i_ra3b,
    output logic [DATA_W-1:0]     o_rd0a,
    output logic [DATA_W-1:0]     o_rd0b,
    output logic [DATA_W-1:0]     o_rd1a,
    output logic [DATA_W-1:0]     o_rd1b,
    output logic [DATA_W-1:0]     o_rd2a,
    output logic [DATA_W-1:0]     o_rd2b,
    output logic [DATA_W-1:0]     o_rd3a,
    output logic [DATA_W-1:0]     o_rd3b,
    output logic                  o_rbusy0a,
    output logic                  o_rbusy0b,
    output logic                  o_rbusy1a,
    output logic                  o_rbusy1b,
    output logic                  o_rbusy2a,
    output logic                  o_rbusy2b,
    output logic                  o_rbusy3a,
    output logic                  o_rbusy3b,
    output logic [TAG_W-1:0]      o_rtag0a,
    output logic [TAG_W-1:0]      o_rtag0b,
    output logic [TAG_W-1:0]      o_rtag1a,
    output logic [TAG_W-1:0]      o_rtag1b,
    output logic [TAG_W-1:0]      o_rtag2a,
    output logic [TAG_W-1:0]      o_rtag2b,
    output logic [TAG_W-1:0]      o_rtag3a,
    output logic [TAG_W-1:0]      o_rtag3b
);

    regstat_t              r_regs [NUM_REGS];
    regstat_t              w_next [NUM_REGS];
    commit_t               w_cmt1;
    commit_t               w_cmt2;
    claim_t                w_ren  [NUM_REN];
    logic [REG_ADDR_W-1:0] w_ra   [NUM_RD];
    logic [DATA_W-1:0]     w_rd   [NUM_RD];
    logic                  w_busy [NUM_RD];
    logic [TAG_W-1:0]      w_tag  [NUM_RD];

    assign w_cmt1 = '{we: i_regfile_we1, wa: i_regfile_wa1, wd: i_regfile_wd1, tag: i_regfile_wd1_tag};
    assign w_cmt2 = '{we: i_regfile_we2, wa: i_regfile_wa2, wd: i_regfile_wd2, tag: i_regfile_wd2_tag};
    assign w_ren[0] = '{we: i_ren_we0, wa: i_ren_wa0, tag: i_ren_tag0};
    assign w_ren[1] = '{we: i_ren_we1, wa: i_ren_wa1, tag: i_ren_tag1};
    assign w_ren[2] = '{we: i_ren_we2, wa: i_ren_wa2, tag: i_ren_tag2};
    assign w_ren[3] = '{we: i_ren_we3, wa: i_ren_wa3, tag: i_ren_tag3};

    assign w_ra[0] = i_ra0a;
    assign w_ra[1] = i_ra0b;
    assign w_ra[2] = i_ra1a;
    assign w_ra[3] = i_ra1b;
    assign w_ra[4] = i_ra2a;
    assign w_ra[5] = i_ra2b;
    assign w_ra[6] = i_ra3a;
    assign w_ra[7] = i_ra3b;

    // Per-register next state. Order of precedence inside one register:
    // commit values (port 2 last), commit busy clear against the old tag,
    // then either flush (clears all rename status) or rename claims
    // (ascending index so the youngest claim wins, overriding any clear).
    always_comb begin
        logic [REG_ADDR_W-1:0] v_addr;
        logic                  v_hit1;
        logic                  v_hit2;
        v_addr = '0;
        v_hit1 = 1'b0;
        v_hit2 = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_next[r] = r_regs[r];
            v_addr    = REG_ADDR_W'(r);
            v_hit1    = commit_hits(w_cmt1, v_addr);
            v_hit2    = commit_hits(w_cmt2, v_addr);
            if (r == 0) begin
                w_next[r] = '0;
            end else begin
                if (v_hit1) w_next[r].value = w_cmt1.wd;
                if (v_hit2) w_next[r].value = w_cmt2.wd;
                if ((v_hit1 && (w_cmt1.tag == r_regs[r].tag)) ||
                    (v_hit2 && (w_cmt2.tag == r_regs[r].tag)))
                    w_next[r].busy = 1'b0;
                if (i_flush) begin
                    w_next[r].busy = 1'b0;
                    w_next[r].tag  = '0;
                end else begin
                    for (int k = 0; k < NUM_REN; k++) begin
                        if (w_ren[k].we && (w_ren[k].wa == v_addr)) begin
                            w_next[r].busy = 1'b1;
                            w_next[r].tag  = w_ren[k].tag;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else begin
            r_regs <= w_next;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rdport
        regfile_rdport u_rdport (
            .i_rst_n (i_reset),
            .i_ra    (w_ra[g]),
            .i_regs  (r_regs),
            .i_cmt1  (w_cmt1),
            .i_cmt2  (w_cmt2),
            .o_rd    (w_rd[g]),
            .o_rbusy (w_busy[g]),
            .o_rtag  (w_tag[g])
        );
    end

    assign o_rd0a = w_rd[0];
    assign o_rd0b = w_rd[1];
    assign o_rd1a = w_rd[2];
    assign o_rd1b = w_rd[3];
    assign o_rd2a = w_rd[4];
    assign o_rd2b = w_rd[5];
    assign o_rd3a = w_rd[6];
    assign o_rd3b = w_rd[7];

    assign o_rbusy0a = w_busy[0];
    assign o_rbusy0b = w_busy[1];
    assign o_rbusy1a = w_busy[2];
    assign o_rbusy1b = w_busy[3];
    assign o_rbusy2a = w_busy[4];
    assign o_rbusy2b = w_busy[5];
    assign o_rbusy3a = w_busy[6];
    assign o_rbusy3b = w_busy[7];

    assign o_rtag0a = w_tag[0];
    assign o_rtag0b = w_tag[1];
    assign o_rtag1a = w_tag[2];
    assign o_rtag1b = w_tag[3];
    assign o_rtag2a = w_tag[4];
    assign o_rtag2b = w_tag[5];
    assign o_rtag3a = w_tag[6];
    assign o_rtag3b = w_tag[7];

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: event-ordered reference model plus
// hand-computed literal expectations on directed vectors.
// Reads are compared every cycle on the falling edge.
module tb_regfile_tagged;

    logic        clk = 1'b0;
    logic        reset;
    logic        we1, we2;
    logic [4:0]  wa1, wa2;
    logic [31:0] wd1, wd2, t1, t2;
    logic        ren_we  [4];
    logic [4:0]  ren_wa  [4];
    logic [31:0] ren_tag [4];
    logic        flush;
    logic [4:0]  ra    [8];
    logic [31:0] rd    [8];
    logic        rbusy [8];
    logic [31:0] rtag  [8];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [31:0] m_tag  [32];

    always #5 clk = ~clk;

    regfile_tagged dut (
        .i_clk(clk), .i_reset(reset),
        .i_regfile_we1(we1), .i_regfile_we2(we2),
        .i_regfile_wa1(wa1), .i_regfile_wa2(wa2),
        .i_regfile_wd1(wd1), .i_regfile_wd2(wd2),
        .i_regfile_wd1_tag(t1), .i_regfile_wd2_tag(t2),
        .i_ren_we0(ren_we[0]), .i_ren_we1(ren_we[1]), .i_ren_we2(ren_we[2]), .i_ren_we3(ren_we[3]),
        .i_ren_wa0(ren_wa[0]), .i_ren_wa1(ren_wa[1]), .i_ren_wa2(ren_wa[2]), .i_ren_wa3(ren_wa[3]),
        .i_ren_tag0(ren_tag[0]), .i_ren_tag1(ren_tag[1]), .i_ren_tag2(ren_tag[2]), .i_ren_tag3(ren_tag[3]),
        .i_flush(flush),
        .i_ra0a(ra[0]), .i_ra0b(ra[1]), .i_ra1a(ra[2]), .i_ra1b(ra[3]),
        .i_ra2a(ra[4]), .i_ra2b(ra[5]), .i_ra3a(ra[6]), .i_ra3b(ra[7]),
        .o_rd0a(rd[0]), .o_rd0b(rd[1]), .o_rd1a(rd[2]), .o_rd1b(rd[3]),
        .o_rd2a(rd[4]), .o_rd2b(rd[5]), .o_rd3a(rd[6]), .o_rd3b(rd[7]),
        .o_rbusy0a(rbusy[0]), .o_rbusy0b(rbusy[1]), .o_rbusy1a(rbusy[2]), .o_rbusy1b(rbusy[3]),
        .o_rbusy2a(rbusy[4]), .o_rbusy2b(rbusy[5]), .o_rbusy3a(rbusy[6]), .o_rbusy3b(rbusy[7]),
        .o_rtag0a(rtag[0]), .o_rtag0b(rtag[1]), .o_rtag1a(rtag[2]), .o_rtag1b(rtag[3]),
        .o_rtag2a(rtag[4]), .o_rtag2b(rtag[5]), .o_rtag3a(rtag[6]), .o_rtag3b(rtag[7])
    );

    // What a reader must see this cycle: stored state, overlaid by the
    // committing data, with busy dropping if the commit is the producer.
    function automatic void model_read(input logic [4:0] a, output logic [31:0] v,
                                       output logic b, output logic [31:0] t);
        bit h1, h2;
        v = 0; b = 0; t = 0;
        if (reset && a != 0) begin
            h1 = we1 && wa1 == a;
            h2 = we2 && wa2 == a;
            v = h2 ? wd2 : (h1 ? wd1 : m_val[a]);
            b = m_busy[a];
            if ((h1 && t1 == m_tag[a]) || (h2 && t2 == m_tag[a])) b = 0;
            t = b ? m_tag[a] : 0;
        end
    endfunction

    // Apply one clock's events in program order.
    always @(posedge clk) begin
        bit clr [32];
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
            end
        end else begin
            for (int r = 0; r < 32; r++) clr[r] = 0;
            if (we1 && wa1 != 0) begin
                m_val[wa1] = wd1;
                if (m_tag[wa1] == t1) clr[wa1] = 1;
            end
            if (we2 && wa2 != 0) begin
                m_val[wa2] = wd2;
                if (m_tag[wa2] == t2) clr[wa2] = 1;
            end
            for (int r = 0; r < 32; r++) if (clr[r]) m_busy[r] = 0;
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    m_busy[r] = 0; m_tag[r] = 0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (ren_we[k] && ren_wa[k] != 0) begin
                        m_busy[ren_wa[k]] = 1;
                        m_tag[ren_wa[k]]  = ren_tag[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ev, et;
        logic        eb;
        if (chk_en) begin
            for (int i = 0; i < 8; i++) begin
                model_read(ra[i], ev, eb, et);
                checks++;
                if (rd[i] !== ev) begin
                    errors++;
                    $display("FAIL model rd port%0d addr%0d got %h exp %h at %0t", i, ra[i], rd[i], ev, $time);
                end
                checks++;
                if (rbusy[i] !== eb) begin
                    errors++;
                    $display("FAIL model busy port%0d addr%0d got %b exp %b at %0t", i, ra[i], rbusy[i], eb, $time);
                end
                checks++;
                if (rtag[i] !== et) begin
                    errors++;
                    $display("FAIL model tag port%0d addr%0d got %h exp %h at %0t", i, ra[i], rtag[i], et, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; t1 = 0; t2 = 0;
        flush = 0;
        for (int k = 0; k < 4; k++) begin
            ren_we[k] = 0; ren_wa[k] = 0; ren_tag[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic claim(input int k, input logic [4:0] a, input logic [31:0] t);
        ren_we[k] = 1; ren_wa[k] = a; ren_tag[k] = t;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
        end
        reset = 0;
        idle();
        for (int i = 0; i < 8; i++) ra[i] = 5'(i * 3 + 1);

        // Reset held two cycles; also a commit present to prove reads stay 0.
        we1 = 1; wa1 = 1; wd1 = 32'hAAAA_5555;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                chk("reset_rd", rd[i], 0);
                chk("reset_busy", 32'(rbusy[i]), 0);
                chk("reset_tag", rtag[i], 0);
            end
            @(posedge clk); #1;
            chk_en = 1;
        end
        idle();
        reset = 1;

        // Claim then matching commit: bypassed in-cycle, then from storage.
        ra[0] = 5;
        claim(0, 5, 7); tick();
        @(negedge clk);
        chk("claim_busy", 32'(rbusy[0]), 1);
        chk("claim_tag", rtag[0], 7);
        we1 = 1; wa1 = 5; wd1 = 32'hDEAD_BEEF; t1 = 7;
        @(negedge clk);
        chk("byp_rd", rd[0], 32'hDEAD_BEEF);
        chk("byp_busy", 32'(rbusy[0]), 0);
        chk("byp_tag", rtag[0], 0);
        tick();
        @(negedge clk);
        chk("stored_rd", rd[0], 32'hDEAD_BEEF);
        chk("stored_busy", 32'(rbusy[0]), 0);

        // Stale commit after re-rename keeps the younger producer.
        claim(0, 5, 7); tick();
        claim(0, 5, 9); tick();
        we1 = 1; wa1 = 5; wd1 = 32'h11; t1 = 7;
        @(negedge clk);
        chk("stale_byp_rd", rd[0], 32'h11);
        chk("stale_byp_busy", 32'(rbusy[0]), 1);
        chk("stale_byp_tag", rtag[0], 9);
        tick();
        @(negedge clk);
        chk("stale_rd", rd[0], 32'h11);
        chk("stale_tag", rtag[0], 9);

        // Commit + claim on same register: claim wins busy.
        ra[1] = 3;
        claim(0, 3, 4); tick();
        we1 = 1; wa1 = 3; wd1 = 32'h22; t1 = 4;
        claim(1, 3, 12);
        @(negedge clk);
        chk("cc_byp_busy", 32'(rbusy[1]), 0);
        tick();
        @(negedge clk);
        chk("cc_rd", rd[1], 32'h22);
        chk("cc_busy", 32'(rbusy[1]), 1);
        chk("cc_tag", rtag[1], 12);

        // Two claims to one register: highest index wins.
        ra[2] = 8;
        claim(0, 8, 20); claim(2, 8, 22); tick();
        @(negedge clk);
        chk("multi_busy", 32'(rbusy[2]), 1);
        chk("multi_tag", rtag[2], 22);

        // Both commit ports to R6: port 2 data wins.
        ra[3] = 6;
        we1 = 1; wa1 = 6; wd1 = 1; we2 = 1; wa2 = 6; wd2 = 2;
        @(negedge clk);
        chk("dual_byp_rd", rd[3], 2);
        tick();
        @(negedge clk);
        chk("dual_rd", rd[3], 2);

        // Register 0 ignores commits and claims.
        ra[4] = 0;
        claim(0, 0, 5); we1 = 1; wa1 = 0; wd1 = 32'hFF;
        @(negedge clk);
        chk("r0_byp_rd", rd[4], 0);
        tick();
        @(negedge clk);
        chk("r0_rd", rd[4], 0);
        chk("r0_busy", 32'(rbusy[4]), 0);
        chk("r0_tag", rtag[4], 0);

        // Flush with a simultaneous claim and commit.
        claim(0, 1, 31); claim(1, 2, 32); claim(2, 3, 33); claim(3, 4, 34); tick();
        ra[0] = 1; ra[1] = 2; ra[2] = 3; ra[3] = 4; ra[4] = 10; ra[5] = 5; ra[6] = 7; ra[7] = 8;
        @(negedge clk);
        chk("preflush_busy", 32'(rbusy[3]), 1);
        chk("preflush_tag", rtag[3], 34);
        flush = 1; claim(0, 10, 40); we1 = 1; wa1 = 7; wd1 = 32'h77;
        tick();
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("flush_busy", 32'(rbusy[i]), 0);
        chk("flush_tag10", rtag[4], 0);
        chk("flush_r3", rd[2], 32'h22);
        chk("flush_r5", rd[5], 32'h11);
        chk("flush_r7", rd[6], 32'h77);

        // Mid-run reset, then a commit with a pre-reset tag is stale.
        ra[0] = 9;
        claim(0, 9, 50); tick();
        reset = 0; tick();
        reset = 1;
        we1 = 1; wa1 = 9; wd1 = 32'h99; t1 = 50;
        @(negedge clk);
        chk("postrst_r5", rd[5], 0);
        chk("postrst_byp_rd", rd[0], 32'h99);
        chk("postrst_busy", 32'(rbusy[0]), 0);
        tick();
        @(negedge clk);
        chk("postrst_rd", rd[0], 32'h99);

        // Mixed traffic on a small register window with few tags so
        // matches, collisions and stale commits all occur.
        for (int c = 0; c < 300; c++) begin
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom; t1 = $urandom_range(0, 3);
            we2 = 1'($urandom); wa2 = 5'($urandom_range(0, 7)); wd2 = $urandom; t2 = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                ren_we[k]  = ($urandom_range(0, 2) == 0);
                ren_wa[k]  = 5'($urandom_range(0, 7));
                ren_tag[k] = $urandom_range(0, 3);
            end
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < 8; i++) ra[i] = 5'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        idle();
        reset = 1;
        @(negedge clk);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
